mshr_split_tagged: RTL and testbench

// - Parametrised miss tracker between LSU and memory repair path; separate load/store entry pools.
// - Several repairs may be outstanding at once, each completed by a returned tag {is_store, idx}.
// - Load-over-store priority with a store anti-starvation limit; flush squashes only unissued misses.

---
 rtl/mshr_split_tagged.sv | 243 ++++++++++++++++++++++++
 tb/tb_mshr_split_tagged.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_split_tagged.sv
`default_nettype none
// mshr_split_tagged: split load/store miss tracker; repairs complete out of order by tag {is_store, idx}.
// Optional feature macro: MSHR_LD_MERGE_EN (loads to an already-tracked line merge onto that entry).
module mshr_split_tagged #(
  parameter int LD_ENTS         = 8,
  parameter int ST_ENTS         = 8,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ROB_IDX_W       = 6,
  parameter int LINE_OFF_W      = 4,
  parameter int ST_STARVE_LIMIT = 4,
  localparam int IDX_W    = $clog2((LD_ENTS > ST_ENTS) ? LD_ENTS : ST_ENTS),
  localparam int LD_CNT_W = $clog2(LD_ENTS + 1),
  localparam int ST_CNT_W = $clog2(ST_ENTS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 ld_alloc_valid_i,
  input  logic [ADDR_W-1:0]    ld_alloc_addr_i,
  input  logic [ROB_IDX_W-1:0] ld_alloc_rob_idx_i,
  output logic                 ld_alloc_ready_o,
  output logic [IDX_W-1:0]     ld_alloc_idx_o,
  output logic                 ld_merge_hit_o,
  input  logic                 st_alloc_valid_i,
  input  logic [ADDR_W-1:0]    st_alloc_addr_i,
  input  logic [DATA_W-1:0]    st_alloc_data_i,
  input  logic [ROB_IDX_W-1:0] st_alloc_rob_idx_i,
  output logic                 st_alloc_ready_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 req_is_store_o,
  output logic [IDX_W-1:0]     req_idx_o,
  output logic [ADDR_W-1:0]    req_addr_o,
  output logic [DATA_W-1:0]    req_data_o,
  output logic [ROB_IDX_W-1:0] req_rob_idx_o,
  input  logic                 done_valid_i,
  input  logic                 done_is_store_i,
  input  logic [IDX_W-1:0]     done_idx_i,
  output logic [LD_CNT_W-1:0]  ld_count_o,
  output logic [ST_CNT_W-1:0]  st_count_o
);

  localparam int SC_W = (ST_STARVE_LIMIT > 0) ? $clog2(ST_STARVE_LIMIT + 1) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(ST_STARVE_LIMIT);

  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_PEND   = 2'd1,
    E_ISSUED = 2'd2
  } ent_e;

  ent_e                 ld_st   [LD_ENTS];
  logic [ADDR_W-1:0]    ld_addr [LD_ENTS];
  logic [ROB_IDX_W-1:0] ld_rob  [LD_ENTS];
  ent_e                 st_st   [ST_ENTS];
  logic [ADDR_W-1:0]    st_addr [ST_ENTS];
  logic [DATA_W-1:0]    st_data [ST_ENTS];
  logic [ROB_IDX_W-1:0] st_rob  [ST_ENTS];

  logic             hold_q;
  logic             hold_store_q;
  logic [IDX_W-1:0] hold_idx_q;
  logic [SC_W-1:0]  starve_q;

  logic             ld_free_any, ld_pend_any, st_free_any, st_pend_any;
  logic [IDX_W-1:0] ld_free_idx, ld_pend_idx, st_free_idx, st_pend_idx;
  logic             merge_ok;
  logic [IDX_W-1:0] merge_idx;
  logic             sel_valid, sel_store;
  logic [IDX_W-1:0] sel_idx;
  logic             grant, ld_fire, st_fire;

  always_comb begin
    ld_free_any = 1'b0;
    ld_free_idx = '0;
    ld_pend_any = 1'b0;
    ld_pend_idx = '0;
    ld_count_o  = '0;
    for (int i = LD_ENTS - 1; i >= 0; i--) begin
      if (ld_st[i] == E_FREE) begin
        ld_free_any = 1'b1;
        ld_free_idx = IDX_W'(i);
      end
      if (ld_st[i] == E_PEND) begin
        ld_pend_any = 1'b1;
        ld_pend_idx = IDX_W'(i);
      end
      ld_count_o = ld_count_o + LD_CNT_W'(ld_st[i] != E_FREE);
    end
  end

  always_comb begin
    st_free_any = 1'b0;
    st_free_idx = '0;
    st_pend_any = 1'b0;
    st_pend_idx = '0;
    st_count_o  = '0;
    for (int i = ST_ENTS - 1; i >= 0; i--) begin
      if (st_st[i] == E_FREE) begin
        st_free_any = 1'b1;
        st_free_idx = IDX_W'(i);
      end
      if (st_st[i] == E_PEND) begin
        st_pend_any = 1'b1;
        st_pend_idx = IDX_W'(i);
      end
      st_count_o = st_count_o + ST_CNT_W'(st_st[i] != E_FREE);
    end
  end

`ifdef MSHR_LD_MERGE_EN
  // A merge is a line match against any tracked load; merges are suppressed while flushing.
  always_comb begin
    merge_ok  = 1'b0;
    merge_idx = '0;
    for (int i = LD_ENTS - 1; i >= 0; i--) begin
      if (ld_st[i] != E_FREE &&
          ld_addr[i][ADDR_W-1:LINE_OFF_W] == ld_alloc_addr_i[ADDR_W-1:LINE_OFF_W]) begin
        merge_ok  = !flush_i;
        merge_idx = IDX_W'(i);
      end
    end
  end
`else
  assign merge_ok  = 1'b0;
  assign merge_idx = '0;
`endif

  assign ld_merge_hit_o   = ld_alloc_valid_i && merge_ok;
  assign ld_alloc_ready_o = ld_free_any || merge_ok;
  assign ld_alloc_idx_o   = merge_ok ? merge_idx : ld_free_idx;
  assign st_alloc_ready_o = st_free_any;
  assign ld_fire = ld_alloc_valid_i && ld_free_any && !merge_ok && !flush_i;
  assign st_fire = st_alloc_valid_i && st_free_any && !flush_i;

  // A stalled request is pinned so a newly pending lower index cannot displace it.
  always_comb begin
    sel_valid = 1'b0;
    sel_store = 1'b0;
    sel_idx   = '0;
    if (hold_q) begin
      sel_valid = 1'b1;
      sel_store = hold_store_q;
      sel_idx   = hold_idx_q;
    end else if (st_pend_any && (!ld_pend_any || starve_q == STARVE_MAX)) begin
      sel_valid = 1'b1;
      sel_store = 1'b1;
      sel_idx   = st_pend_idx;
    end else if (ld_pend_any) begin
      sel_valid = 1'b1;
      sel_idx   = ld_pend_idx;
    end
  end

  always_comb begin
    req_addr_o    = '0;
    req_data_o    = '0;
    req_rob_idx_o = '0;
    for (int i = 0; i < LD_ENTS; i++) begin
      if (sel_valid && !sel_store && IDX_W'(i) == sel_idx) begin
        req_addr_o    = ld_addr[i];
        req_rob_idx_o = ld_rob[i];
      end
    end
    for (int i = 0; i < ST_ENTS; i++) begin
      if (sel_valid && sel_store && IDX_W'(i) == sel_idx) begin
        req_addr_o    = st_addr[i];
        req_data_o    = st_data[i];
        req_rob_idx_o = st_rob[i];
      end
    end
  end

  assign req_valid_o    = sel_valid;
  assign req_is_store_o = sel_valid && sel_store;
  assign req_idx_o      = sel_valid ? sel_idx : '0;
  assign grant          = sel_valid && req_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LD_ENTS; i++) begin
        ld_st[i]   <= E_FREE;
        ld_addr[i] <= '0;
        ld_rob[i]  <= '0;
      end
      for (int i = 0; i < ST_ENTS; i++) begin
        st_st[i]   <= E_FREE;
        st_addr[i] <= '0;
        st_data[i] <= '0;
        st_rob[i]  <= '0;
      end
      hold_q       <= 1'b0;
      hold_store_q <= 1'b0;
      hold_idx_q   <= '0;
      starve_q     <= '0;
    end else begin
      for (int i = 0; i < LD_ENTS; i++) begin
        case (ld_st[i])
          E_FREE: if (ld_fire && ld_free_idx == IDX_W'(i)) begin
            ld_st[i]   <= E_PEND;
            ld_addr[i] <= ld_alloc_addr_i;
            ld_rob[i]  <= ld_alloc_rob_idx_i;
          end
          E_PEND: begin
            if (grant && !sel_store && sel_idx == IDX_W'(i)) ld_st[i] <= E_ISSUED;
            else if (flush_i)                                ld_st[i] <= E_FREE;
          end
          E_ISSUED: if (done_valid_i && !done_is_store_i && done_idx_i == IDX_W'(i))
            ld_st[i] <= E_FREE;
          default: ld_st[i] <= E_FREE;
        endcase
      end
      for (int i = 0; i < ST_ENTS; i++) begin
        case (st_st[i])
          E_FREE: if (st_fire && st_free_idx == IDX_W'(i)) begin
            st_st[i]   <= E_PEND;
            st_addr[i] <= st_alloc_addr_i;
            st_data[i] <= st_alloc_data_i;
            st_rob[i]  <= st_alloc_rob_idx_i;
          end
          E_PEND: begin
            if (grant && sel_store && sel_idx == IDX_W'(i)) st_st[i] <= E_ISSUED;
            else if (flush_i)                               st_st[i] <= E_FREE;
          end
          E_ISSUED: if (done_valid_i && done_is_store_i && done_idx_i == IDX_W'(i))
            st_st[i] <= E_FREE;
          default: st_st[i] <= E_FREE;
        endcase
      end

      hold_q       <= sel_valid && !req_ready_i && !flush_i;
      hold_store_q <= sel_store;
      hold_idx_q   <= sel_idx;

      if (!st_pend_any)                          starve_q <= '0;
      else if (grant && sel_store)               starve_q <= '0;
      else if (grant && starve_q != STARVE_MAX)  starve_q <= starve_q + SC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mshr_split_tagged.sv
`default_nettype none
// tb_mshr_split_tagged: vector table, directed corner sequences and randomized traffic
// checked every cycle against an entry-array reference model.
module tb_mshr_split_tagged;
  localparam int LD = 8, ST = 8, LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ld_v = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [5:0]  ld_rob = '0;
  logic        ld_ready, merge_hit;
  logic [2:0]  ld_idx;
  logic        st_v = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [5:0]  st_rob = '0;
  logic        st_ready;
  logic        req_v, req_ready = 1'b0, req_st;
  logic [2:0]  req_idx;
  logic [31:0] req_addr, req_data;
  logic [5:0]  req_rob;
  logic        done_v = 1'b0, done_st = 1'b0;
  logic [2:0]  done_idx = '0;
  logic [3:0]  ld_cnt, st_cnt;

  mshr_split_tagged dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .ld_alloc_valid_i(ld_v), .ld_alloc_addr_i(ld_addr), .ld_alloc_rob_idx_i(ld_rob),
    .ld_alloc_ready_o(ld_ready), .ld_alloc_idx_o(ld_idx), .ld_merge_hit_o(merge_hit),
    .st_alloc_valid_i(st_v), .st_alloc_addr_i(st_addr), .st_alloc_data_i(st_data),
    .st_alloc_rob_idx_i(st_rob), .st_alloc_ready_o(st_ready),
    .req_valid_o(req_v), .req_ready_i(req_ready), .req_is_store_o(req_st),
    .req_idx_o(req_idx), .req_addr_o(req_addr), .req_data_o(req_data), .req_rob_idx_o(req_rob),
    .done_valid_i(done_v), .done_is_store_i(done_st), .done_idx_i(done_idx),
    .ld_count_o(ld_cnt), .st_count_o(st_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: entry state 0 = free, 1 = waiting for issue, 2 = outstanding.
  int          m_ld_st [LD];
  logic [31:0] m_ld_addr [LD];
  logic [5:0]  m_ld_rob [LD];
  int          m_st_st [ST];
  logic [31:0] m_st_addr [ST], m_st_data [ST];
  logic [5:0]  m_st_rob [ST];
  bit          m_hold, m_hold_st;
  int          m_hold_idx, m_starve;
  int          m_ld_free, m_st_free, m_match;
  bit          o_ld_ready, o_merge, o_st_ready, o_req_v, o_req_st;
  int          o_ld_idx, o_req_idx, o_ld_cnt, o_st_cnt;
  logic [31:0] o_req_addr, o_req_data;
  logic [5:0]  o_req_rob;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < LD; i++) begin m_ld_st[i] = 0; m_ld_addr[i] = '0; m_ld_rob[i] = '0; end
    for (int i = 0; i < ST; i++) begin
      m_st_st[i] = 0; m_st_addr[i] = '0; m_st_data[i] = '0; m_st_rob[i] = '0;
    end
    m_hold = 0; m_hold_st = 0; m_hold_idx = 0; m_starve = 0;
  endfunction

  function automatic void model_eval();
    int lp, sp;
    bit hit_ok;
    m_ld_free = -1; m_st_free = -1; m_match = -1; lp = -1; sp = -1;
    o_ld_cnt = 0; o_st_cnt = 0;
    for (int i = 0; i < LD; i++) begin
      if (m_ld_st[i] == 0 && m_ld_free < 0) m_ld_free = i;
      if (m_ld_st[i] == 1 && lp < 0) lp = i;
      if (m_ld_st[i] != 0) begin
        o_ld_cnt++;
        if (m_match < 0 && (m_ld_addr[i] >> 4) == (ld_addr >> 4)) m_match = i;
      end
    end
    for (int i = 0; i < ST; i++) begin
      if (m_st_st[i] == 0 && m_st_free < 0) m_st_free = i;
      if (m_st_st[i] == 1 && sp < 0) sp = i;
      if (m_st_st[i] != 0) o_st_cnt++;
    end
`ifdef MSHR_LD_MERGE_EN
    hit_ok = (m_match >= 0) && !flush;
`else
    hit_ok = 0;
`endif
    o_merge    = hit_ok && ld_v;
    o_ld_ready = (m_ld_free >= 0) || hit_ok;
    o_ld_idx   = hit_ok ? m_match : ((m_ld_free >= 0) ? m_ld_free : 0);
    o_st_ready = (m_st_free >= 0);
    o_req_v = 0; o_req_st = 0; o_req_idx = 0;
    if (m_hold) begin
      o_req_v = 1; o_req_st = m_hold_st; o_req_idx = m_hold_idx;
    end else if (sp >= 0 && (lp < 0 || m_starve == LIM)) begin
      o_req_v = 1; o_req_st = 1; o_req_idx = sp;
    end else if (lp >= 0) begin
      o_req_v = 1; o_req_idx = lp;
    end
    o_req_addr = '0; o_req_data = '0; o_req_rob = '0;
    if (o_req_v && o_req_st) begin
      o_req_addr = m_st_addr[o_req_idx]; o_req_data = m_st_data[o_req_idx];
      o_req_rob = m_st_rob[o_req_idx];
    end else if (o_req_v) begin
      o_req_addr = m_ld_addr[o_req_idx]; o_req_rob = m_ld_rob[o_req_idx];
    end
  endfunction

  function automatic void model_step();
    int  nl [LD];
    int  ns [ST];
    bit  st_pend, grant;
    st_pend = 0;
    for (int i = 0; i < ST; i++) if (m_st_st[i] == 1) st_pend = 1;
    grant = o_req_v && req_ready;
    nl = m_ld_st; ns = m_st_st;
    if (flush) begin
      for (int i = 0; i < LD; i++) if (m_ld_st[i] == 1) nl[i] = 0;
      for (int i = 0; i < ST; i++) if (m_st_st[i] == 1) ns[i] = 0;
    end
    if (grant) begin
      if (o_req_st) ns[o_req_idx] = 2; else nl[o_req_idx] = 2;
    end
    if (done_v) begin
      if (done_st && m_st_st[done_idx] == 2) ns[done_idx] = 0;
      if (!done_st && m_ld_st[done_idx] == 2) nl[done_idx] = 0;
    end
    if (!flush && ld_v && !o_merge && m_ld_free >= 0) begin
      nl[m_ld_free] = 1; m_ld_addr[m_ld_free] = ld_addr; m_ld_rob[m_ld_free] = ld_rob;
    end
    if (!flush && st_v && m_st_free >= 0) begin
      ns[m_st_free] = 1; m_st_addr[m_st_free] = st_addr;
      m_st_data[m_st_free] = st_data; m_st_rob[m_st_free] = st_rob;
    end
    if (!st_pend) m_starve = 0;
    else if (grant && o_req_st) m_starve = 0;
    else if (grant && m_starve < LIM) m_starve++;
    m_hold = o_req_v && !req_ready && !flush;
    m_hold_st = o_req_st; m_hold_idx = o_req_idx;
    m_ld_st = nl; m_st_st = ns;
  endfunction

  // Compare against the model just before the edge, then advance both.
  task automatic cycle();
    #1;
    model_eval();
    chk("ld_alloc_ready", ld_ready, o_ld_ready);
    chk("ld_alloc_idx", ld_idx, o_ld_idx);
    chk("ld_merge_hit", merge_hit, o_merge);
    chk("st_alloc_ready", st_ready, o_st_ready);
    chk("req_valid", req_v, o_req_v);
    chk("req_is_store", req_st, o_req_st);
    chk("req_idx", req_idx, o_req_idx);
    chk("req_addr", req_addr, o_req_addr);
    chk("req_data", req_data, o_req_data);
    chk("req_rob", req_rob, o_req_rob);
    chk("ld_count", ld_cnt, o_ld_cnt);
    chk("st_count", st_cnt, o_st_cnt);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    ld_v = 0; st_v = 0; flush = 0; done_v = 0; req_ready = 1;
    repeat (20) cycle();
    req_ready = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) begin
        done_v = 1; done_st = p[0]; done_idx = 3'(i);
        cycle();
      end
    done_v = 0;
    #1;
    chk("drain_ld_count", ld_cnt, 0);
    chk("drain_st_count", st_cnt, 0);
  endtask

  typedef struct {
    bit          ld_v;
    logic [31:0] ld_addr;
    bit          done_v;
    int          done_idx;
    bit          e_req_v;
    int          e_req_idx;
    logic [31:0] e_req_addr;
    int          e_ld_cnt;
    int          e_ld_idx;
  } vec_t;

  vec_t vt [9];
  int   exp_st [7];
  int   exp_ix [7];

  initial begin
    vt[0] = '{1, 32'h100, 0, 0, 0, 0, 32'h0,   0, 0};
    vt[1] = '{1, 32'h200, 0, 0, 1, 0, 32'h100, 1, 1};
    vt[2] = '{1, 32'h300, 0, 0, 1, 1, 32'h200, 2, 2};
    vt[3] = '{0, 32'h0,   0, 0, 1, 2, 32'h300, 3, 3};
    vt[4] = '{0, 32'h0,   0, 0, 0, 0, 32'h0,   3, 3};
    vt[5] = '{0, 32'h0,   1, 0, 0, 0, 32'h0,   3, 3};
    vt[6] = '{0, 32'h0,   1, 1, 0, 0, 32'h0,   2, 0};
    vt[7] = '{0, 32'h0,   1, 2, 0, 0, 32'h0,   1, 0};
    vt[8] = '{0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0};
    exp_st = '{0, 0, 0, 0, 1, 0, 0};
    exp_ix = '{0, 1, 2, 3, 0, 4, 5};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    #1;
    chk("reset_req_valid", req_v, 0);
    chk("reset_st_ready", st_ready, 1);
    chk("reset_st_count", st_cnt, 0);
    chk("reset_req_addr", req_addr, 0);

    // Three back-to-back loads issue one per cycle, then complete.
    req_ready = 1;
    for (int k = 0; k < 9; k++) begin
      ld_v = vt[k].ld_v; ld_addr = vt[k].ld_addr; ld_rob = 6'(k);
      done_v = vt[k].done_v; done_st = 0; done_idx = 3'(vt[k].done_idx);
      #1;
      chk("vec_req_valid", req_v, vt[k].e_req_v);
      chk("vec_req_idx", req_idx, vt[k].e_req_idx);
      chk("vec_req_addr", req_addr, vt[k].e_req_addr);
      chk("vec_ld_count", ld_cnt, vt[k].e_ld_cnt);
      chk("vec_ld_ready", ld_ready, 1);
      chk("vec_ld_idx", ld_idx, vt[k].e_ld_idx);
      cycle();
    end
    ld_v = 0; done_v = 0;

    // Fill the load pool, overflow, and reuse a slot freed by done.
    req_ready = 0;
    for (int k = 0; k < 8; k++) begin
      ld_v = 1; ld_addr = 32'h1000 + 32'(k) * 32'h40; ld_rob = 6'(k);
      cycle();
    end
    ld_addr = 32'h2000;
    #1;
    chk("full_ld_ready", ld_ready, 0);
    chk("full_ld_count", ld_cnt, 8);
    cycle();
    ld_v = 0;
    #1;
    chk("full_9th_ignored", ld_cnt, 8);
    req_ready = 1;
    repeat (6) cycle();
    req_ready = 0;
    ld_v = 1; done_v = 1; done_st = 0; done_idx = 3'd5;
    #1;
    chk("done_same_cycle_ready", ld_ready, 0);
    cycle();
    done_v = 0;
    #1;
    chk("after_done_ready", ld_ready, 1);
    chk("after_done_idx", ld_idx, 5);
    cycle();
    ld_v = 0;
    #1;
    chk("refill_count", ld_cnt, 8);
    drain();

    // Store anti-starvation: 4 load grants, then the store, then the rest.
    req_ready = 0;
    st_v = 1; st_addr = 32'h3000; st_data = 32'hDEAD_BEEF; st_rob = 6'd33;
    ld_v = 1; ld_addr = 32'h4000;
    cycle();
    st_v = 0;
    for (int k = 1; k < 6; k++) begin
      ld_addr = 32'h4000 + 32'(k) * 32'h100;
      cycle();
    end
    ld_v = 0; req_ready = 1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("starve_req_valid", req_v, 1);
      chk("starve_is_store", req_st, exp_st[k]);
      chk("starve_idx", req_idx, exp_ix[k]);
      chk("starve_data", req_data, exp_st[k] != 0 ? 32'hDEAD_BEEF : 32'h0);
      cycle();
    end
    drain();

    // Stalled request stays frozen while a lower index becomes pending.
    req_ready = 1;
    ld_v = 1; ld_addr = 32'h5000; cycle();
    ld_addr = 32'h5100; cycle();
    ld_v = 0; cycle();
    req_ready = 0;
    ld_v = 1; ld_addr = 32'h5200; cycle();
    ld_v = 0; done_v = 1; done_st = 0; done_idx = 3'd0;
    #1;
    chk("hold_first_idx", req_idx, 2);
    cycle();
    done_v = 0; ld_v = 1; ld_addr = 32'h5300;
    #1;
    chk("hold_new_alloc_idx", ld_idx, 0);
    cycle();
    ld_v = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_valid", req_v, 1);
      chk("hold_idx", req_idx, 2);
      chk("hold_addr", req_addr, 32'h5200);
      cycle();
    end
    req_ready = 1;
    #1;
    chk("hold_accept_idx", req_idx, 2);
    cycle();
    #1;
    chk("post_hold_idx", req_idx, 0);
    chk("post_hold_addr", req_addr, 32'h5300);
    cycle();
    drain();

    // Flush with two outstanding and three pending; the concurrent alloc is dropped.
    req_ready = 1;
    ld_v = 1; ld_addr = 32'h6000; cycle();
    ld_addr = 32'h6100; cycle();
    ld_v = 0; cycle();
    req_ready = 0;
    ld_v = 1; ld_addr = 32'h6200; st_v = 1; st_addr = 32'h6800; st_data = 32'h1234;
    cycle();
    st_v = 0; ld_addr = 32'h6300; cycle();
    ld_addr = 32'h7000; flush = 1; cycle();
    flush = 0; ld_v = 0;
    #1;
    chk("flush_ld_count", ld_cnt, 2);
    chk("flush_st_count", st_cnt, 0);
    chk("flush_req_valid", req_v, 0);
    done_v = 1; done_st = 0; done_idx = 3'd0; cycle();
    done_idx = 3'd1; cycle();
    done_v = 0;
    #1;
    chk("flush_done_count", ld_cnt, 0);

    // Same-line load: merges only when the feature is built in.
    ld_v = 1; ld_addr = 32'h100; cycle();
    ld_addr = 32'h104;
    #1;
`ifdef MSHR_LD_MERGE_EN
    chk("merge_hit", merge_hit, 1);
    chk("merge_idx", ld_idx, 0);
`else
    chk("merge_hit", merge_hit, 0);
    chk("merge_idx", ld_idx, 1);
`endif
    cycle();
    ld_v = 0;
    #1;
`ifdef MSHR_LD_MERGE_EN
    chk("merge_count", ld_cnt, 1);
`else
    chk("merge_count", ld_cnt, 2);
`endif
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      ld_v = 1'($urandom);
      ld_addr = (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      ld_rob = 6'($urandom);
      st_v = 1'($urandom);
      st_addr = 32'($urandom);
      st_data = 32'($urandom);
      st_rob = 6'($urandom);
      req_ready = 1'($urandom);
      done_v = 1'($urandom);
      done_st = 1'($urandom);
      done_idx = 3'($urandom);
      flush = ($urandom_range(0, 31) == 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
